// File: rtl/garage_door_plant.sv
// Garage door plant: turns motor commands into door travel and limit-switch
// feedback, and latches a fault on illegal motor usage.
module garage_door_plant #(
  parameter int unsigned POS_W       = 8,
  parameter int unsigned TRAVEL_MAX  = 200,
  parameter int unsigned PRESCALE    = 4,
  parameter int unsigned RESET_POS   = 0,
  parameter int unsigned OVERRUN_MAX = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Up_Motor,
  input  logic             Down_Motor,
  input  logic             Clear_Fault,
  output logic             Up_Max,
  output logic             Down_Max,
  output logic [POS_W-1:0] Position,
  output logic             Moving,
  output logic             Fault
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned OV_W = $clog2(OVERRUN_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RISING  = 2'd1,
    FALLING = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [POS_W-1:0]  r_pos, w_pos_nxt;
  logic [PS_W-1:0]   r_presc, w_presc_nxt;
  logic [OV_W-1:0]   r_ovr, w_ovr_nxt;

  logic w_at_top;
  logic w_at_bot;
  logic w_wrap;
  logic w_ovr_hit;

  assign w_at_top  = (r_pos == POS_W'(TRAVEL_MAX));
  assign w_at_bot  = (r_pos == '0);
  assign w_wrap    = (r_presc == PS_W'(PRESCALE - 1));
  assign w_ovr_hit = (r_ovr == OV_W'(OVERRUN_MAX - 1));

  // State, position, prescaler and overrun registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_pos   <= POS_W'(RESET_POS);
      r_presc <= '0;
      r_ovr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      r_presc <= w_presc_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  // Next-state logic; both-motors fault beats reversal, reversal beats overrun
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_presc_nxt = r_presc;
    w_ovr_nxt   = r_ovr;
    case (r_state)
      IDLE: begin
        w_presc_nxt = '0;
        w_ovr_nxt   = '0;
        if (Up_Motor && Down_Motor)  w_state_nxt = FAULT;
        else if (Up_Motor)           w_state_nxt = RISING;
        else if (Down_Motor)         w_state_nxt = FALLING;
      end
      RISING: begin
        if (Up_Motor && Down_Motor) begin
          w_state_nxt = FAULT;
          w_presc_nxt = '0;
          w_ovr_nxt   = '0;
        end else if (Down_Motor) begin
          w_state_nxt = FALLING;
          w_presc_nxt = '0;
          w_ovr_nxt   = '0;
        end else if (!Up_Motor) begin
          w_state_nxt = IDLE;
          w_presc_nxt = '0;
          w_ovr_nxt   = '0;
        end else if (w_at_top) begin
          w_presc_nxt = '0;
          if (w_ovr_hit) begin
            w_state_nxt = FAULT;
            w_ovr_nxt   = '0;
          end else begin
            w_ovr_nxt = r_ovr + OV_W'(1);
          end
        end else begin
          w_ovr_nxt = '0;
          if (w_wrap) begin
            w_presc_nxt = '0;
            w_pos_nxt   = r_pos + POS_W'(1);
          end else begin
            w_presc_nxt = r_presc + PS_W'(1);
          end
        end
      end
      FALLING: begin
        if (Up_Motor && Down_Motor) begin
          w_state_nxt = FAULT;
          w_presc_nxt = '0;
          w_ovr_nxt   = '0;
        end else if (Up_Motor) begin
          w_state_nxt = RISING;
          w_presc_nxt = '0;
          w_ovr_nxt   = '0;
        end else if (!Down_Motor) begin
          w_state_nxt = IDLE;
          w_presc_nxt = '0;
          w_ovr_nxt   = '0;
        end else if (w_at_bot) begin
          w_presc_nxt = '0;
          if (w_ovr_hit) begin
            w_state_nxt = FAULT;
            w_ovr_nxt   = '0;
          end else begin
            w_ovr_nxt = r_ovr + OV_W'(1);
          end
        end else begin
          w_ovr_nxt = '0;
          if (w_wrap) begin
            w_presc_nxt = '0;
            w_pos_nxt   = r_pos - POS_W'(1);
          end else begin
            w_presc_nxt = r_presc + PS_W'(1);
          end
        end
      end
      FAULT: begin
        w_presc_nxt = '0;
        w_ovr_nxt   = '0;
        if (Clear_Fault && !Up_Motor && !Down_Motor) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs decode registered state and position only
  assign Position = r_pos;
  assign Up_Max   = w_at_top;
  assign Down_Max = w_at_bot;
  assign Fault    = (r_state == FAULT);
  assign Moving   = ((r_state == RISING) && !w_at_top) ||
                    ((r_state == FALLING) && !w_at_bot);

endmodule

// File: tb/tb_garage_door_plant.sv
// Directed bench for garage_door_plant with small travel and prescale values.
module tb_garage_door_plant;

  logic       CLK;
  logic       RST;
  logic       Up_Motor;
  logic       Down_Motor;
  logic       Clear_Fault;
  logic       Up_Max;
  logic       Down_Max;
  logic [7:0] Position;
  logic       Moving;
  logic       Fault;

  int n_total;
  int n_bad;

  garage_door_plant #(
    .POS_W      (8),
    .TRAVEL_MAX (10),
    .PRESCALE   (2),
    .RESET_POS  (0),
    .OVERRUN_MAX(4)
  ) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .Up_Motor   (Up_Motor),
    .Down_Motor (Down_Motor),
    .Clear_Fault(Clear_Fault),
    .Up_Max     (Up_Max),
    .Down_Max   (Down_Max),
    .Position   (Position),
    .Moving     (Moving),
    .Fault      (Fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic up, input logic dn, input logic clr);
    Up_Motor    = up;
    Down_Motor  = dn;
    Clear_Fault = clr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    RST = 1'b0;
    set_in(1'b0, 1'b0, 1'b0);

    // 1. reset state
    #12;
    chk("rst_pos",      32'(Position), 0);
    chk("rst_down_max", 32'(Down_Max), 1);
    chk("rst_up_max",   32'(Up_Max),   0);
    chk("rst_fault",    32'(Fault),    0);
    chk("rst_moving",   32'(Moving),   0);
    RST = 1'b1;
    step(2);
    chk("idle_hold_pos", 32'(Position), 0);

    // 2. full rise
    set_in(1'b1, 1'b0, 1'b0);
    step(1);
    chk("e1_moving",   32'(Moving),   1);
    chk("e1_pos",      32'(Position), 0);
    step(2);
    chk("e3_pos",      32'(Position), 1);
    chk("e3_down_max", 32'(Down_Max), 0);
    step(16);
    chk("e19_pos",     32'(Position), 9);
    chk("e19_up_max",  32'(Up_Max),   0);
    step(2);
    chk("e21_pos",     32'(Position), 10);
    chk("e21_up_max",  32'(Up_Max),   1);
    chk("e21_moving",  32'(Moving),   0);

    // 3. overrun at top, clear rules
    step(3);
    chk("e24_fault",   32'(Fault),    0);
    chk("e24_pos",     32'(Position), 10);
    step(1);
    chk("e25_fault",   32'(Fault),    1);
    set_in(1'b1, 1'b0, 1'b1);
    step(1);
    chk("clr_motor_on_fault", 32'(Fault), 1);
    set_in(1'b0, 1'b0, 1'b1);
    step(1);
    chk("clr_fault",   32'(Fault),    0);
    chk("clr_pos",     32'(Position), 10);
    chk("clr_moving",  32'(Moving),   0);
    set_in(1'b0, 1'b0, 1'b1);
    step(1);
    chk("clr_ignored_idle", 32'(Fault), 0);

    // 4. fall then reverse
    set_in(1'b0, 1'b1, 1'b0);
    step(8);
    chk("fall8_pos",    32'(Position), 7);
    chk("fall8_moving", 32'(Moving),   1);
    set_in(1'b1, 1'b0, 1'b0);
    step(1);
    chk("rev_e0_pos",   32'(Position), 7);
    step(1);
    chk("rev_e1_pos",   32'(Position), 7);
    step(1);
    chk("rev_e2_pos",   32'(Position), 8);

    // 5. both motors in RISING and in IDLE
    set_in(1'b1, 1'b1, 1'b0);
    step(1);
    chk("both_rise_fault",  32'(Fault),    1);
    chk("both_rise_pos",    32'(Position), 8);
    chk("both_rise_moving", 32'(Moving),   0);
    set_in(1'b0, 1'b0, 1'b1);
    step(1);
    chk("both_rise_clr", 32'(Fault), 0);
    set_in(1'b1, 1'b1, 1'b0);
    step(1);
    chk("both_idle_fault", 32'(Fault),    1);
    chk("both_idle_pos",   32'(Position), 8);
    step(3);
    chk("fault_pos_frozen", 32'(Position), 8);
    set_in(1'b0, 1'b0, 1'b1);
    step(1);
    chk("both_idle_clr", 32'(Fault), 0);

    // 6. async reset mid-rise at position 5
    set_in(1'b0, 1'b1, 1'b0);
    step(7);
    chk("pre_rst_fall_pos", 32'(Position), 5);
    set_in(1'b1, 1'b0, 1'b0);
    step(1);
    chk("pre_rst_pos",    32'(Position), 5);
    chk("pre_rst_moving", 32'(Moving),   1);
    #2;
    RST = 1'b0;
    #1;
    chk("arst_pos",      32'(Position), 0);
    chk("arst_down_max", 32'(Down_Max), 1);
    chk("arst_moving",   32'(Moving),   0);
    set_in(1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    step(3);
    chk("post_rst_pos",    32'(Position), 0);
    chk("post_rst_moving", 32'(Moving),   0);

    // bottom overrun: FALLING at position 0
    set_in(1'b0, 1'b1, 1'b0);
    step(1);
    chk("bot_moving", 32'(Moving), 0);
    step(3);
    chk("bot_e4_fault", 32'(Fault),    0);
    step(1);
    chk("bot_e5_fault", 32'(Fault),    1);
    chk("bot_e5_pos",   32'(Position), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
